// File: rtl/rdmap_s2mm_feeder.sv
// rdmap_s2mm_feeder: drains the RD-map IQ command/data FWFT FIFOs into an AXI
// DataMover S2MM channel, tracks outstanding commands, checks returned status
// and raises a stretched frame-done interrupt once a full RD map is committed.
// Optional build macro: RDMAP_S2MM_TIMEOUT_EN enables the data-stall watchdog
// that drives timeout_err; without it timeout_err is tied to 0.
module rdmap_s2mm_feeder #(
    parameter int unsigned BURST_BEATS      = 256,
    parameter int unsigned MAX_OUTSTANDING  = 8,
    parameter int unsigned BURSTS_PER_FRAME = 128,
    parameter int unsigned IRQ_WIDTH        = 24,
    parameter int unsigned TIMEOUT_CYCLES   = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  cmd_fifo_dout,
    input  logic         cmd_fifo_empty,
    output logic         cmd_fifo_rd_en,
    input  logic [127:0] data_fifo_dout,
    input  logic         data_fifo_empty,
    output logic         data_fifo_rd_en,
    output logic [71:0]  m_axis_s2mm_cmd_tdata,
    output logic         m_axis_s2mm_cmd_tvalid,
    input  logic         m_axis_s2mm_cmd_tready,
    output logic [127:0] m_axis_s2mm_tdata,
    output logic [15:0]  m_axis_s2mm_tkeep,
    output logic         m_axis_s2mm_tlast,
    output logic         m_axis_s2mm_tvalid,
    input  logic         m_axis_s2mm_tready,
    input  logic [7:0]   s_axis_s2mm_sts_tdata,
    input  logic         s_axis_s2mm_sts_tvalid,
    output logic         s_axis_s2mm_sts_tready,
    input  logic         err_clr,
    output logic [4:0]   err_flags,
    output logic         timeout_err,
    output logic         frame_done_irq
);

    localparam int unsigned BEAT_W = $clog2(BURST_BEATS);
    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned FRM_W  = $clog2(BURSTS_PER_FRAME);
    localparam int unsigned IRQ_W  = $clog2(IRQ_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          tag;
    logic [3:0]          exp_tag;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [OUT_W-1:0]    outstanding;
    logic [FRM_W-1:0]    burst_cnt;
    logic [IRQ_W-1:0]    irq_cnt;
    logic                cmd_hs;
    logic                data_hs;
    logic                last_hs;
    logic                sts_exp;
    logic                sts_good;
    logic                frame_done;
    logic [4:0]          err_set;

    // AXIS payloads are straight passthrough of the FIFO heads
    assign m_axis_s2mm_cmd_tdata  = {4'h0, tag, cmd_fifo_dout};
    assign m_axis_s2mm_tdata      = data_fifo_dout;
    assign m_axis_s2mm_tkeep      = 16'hFFFF;
    assign s_axis_s2mm_sts_tready = 1'b1;
    assign m_axis_s2mm_tlast      = (state == DATA) && (beat_cnt == BEAT_W'(BURST_BEATS - 1));
    assign frame_done_irq         = (irq_cnt != '0);

    assign cmd_hs     = m_axis_s2mm_cmd_tvalid & m_axis_s2mm_cmd_tready;
    assign data_hs    = m_axis_s2mm_tvalid & m_axis_s2mm_tready;
    assign last_hs    = data_hs & m_axis_s2mm_tlast;
    assign sts_exp    = s_axis_s2mm_sts_tvalid && (outstanding != '0);
    assign sts_good   = sts_exp && s_axis_s2mm_sts_tdata[7] && (s_axis_s2mm_sts_tdata[6:4] == 3'b000);
    assign frame_done = sts_good && (burst_cnt == FRM_W'(BURSTS_PER_FRAME - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt              = state;
        m_axis_s2mm_cmd_tvalid = 1'b0;
        m_axis_s2mm_tvalid     = 1'b0;
        cmd_fifo_rd_en         = 1'b0;
        data_fifo_rd_en        = 1'b0;
        case (state)
            IDLE: begin
                if (!cmd_fifo_empty && (outstanding < OUT_W'(MAX_OUTSTANDING))) state_nxt = CMD;
            end
            CMD: begin
                m_axis_s2mm_cmd_tvalid = 1'b1;
                cmd_fifo_rd_en         = m_axis_s2mm_cmd_tready;
                if (m_axis_s2mm_cmd_tready) state_nxt = DATA;
            end
            DATA: begin
                m_axis_s2mm_tvalid = !data_fifo_empty;
                data_fifo_rd_en    = !data_fifo_empty && m_axis_s2mm_tready;
                if (!data_fifo_empty && m_axis_s2mm_tready && m_axis_s2mm_tlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status decode into error events; unexpected status only flags itself
    always_comb begin
        err_set = '0;
        if (s_axis_s2mm_sts_tvalid) begin
            if (outstanding == '0) begin
                err_set[4] = 1'b1;
            end else begin
                if (!s_axis_s2mm_sts_tdata[7]) err_set[2:0] = s_axis_s2mm_sts_tdata[6:4];
                if (s_axis_s2mm_sts_tdata[3:0] != exp_tag) err_set[3] = 1'b1;
            end
        end
    end

    // Tag, beat, outstanding, frame and irq bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag         <= '0;
            exp_tag     <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            burst_cnt   <= '0;
            irq_cnt     <= '0;
        end else begin
            if (cmd_hs)       tag      <= tag + 4'd1;
            if (sts_exp)      exp_tag  <= exp_tag + 4'd1;
            if (last_hs)      beat_cnt <= '0;
            else if (data_hs) beat_cnt <= beat_cnt + BEAT_W'(1);
            case ({cmd_hs, sts_exp})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (frame_done)    burst_cnt <= '0;
            else if (sts_good) burst_cnt <= burst_cnt + FRM_W'(1);
            if (frame_done)          irq_cnt <= IRQ_W'(IRQ_WIDTH);
            else if (irq_cnt != '0)  irq_cnt <= irq_cnt - IRQ_W'(1);
        end
    end

    // Sticky error flags; a same-cycle error event wins over err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_flags <= '0;
        else     err_flags <= (err_clr ? 5'b00000 : err_flags) | err_set;
    end

`ifdef RDMAP_S2MM_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               stall_hit;

    assign stall_hit = (state == DATA) && !data_hs && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

    // Stall counter: counts non-handshake cycles in DATA, saturates at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          stall_cnt <= '0;
        else if ((state != DATA) || data_hs)              stall_cnt <= '0;
        else if (stall_cnt != STALL_W'(TIMEOUT_CYCLES))   stall_cnt <= stall_cnt + STALL_W'(1);
    end

    // Sticky watchdog flag; FSM keeps waiting for data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) timeout_err <= 1'b0;
        else     timeout_err <= (err_clr ? 1'b0 : timeout_err) | stall_hit;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_err        = 1'b0;
`endif

endmodule

// File: tb/tb_rdmap_s2mm_feeder.sv
// Directed bench for rdmap_s2mm_feeder with FWFT FIFO models and an AXIS monitor.
module tb_rdmap_s2mm_feeder;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  cmd_fifo_dout;
    logic         cmd_fifo_empty;
    logic         cmd_fifo_rd_en;
    logic [127:0] data_fifo_dout;
    logic         data_fifo_empty;
    logic         data_fifo_rd_en;
    logic [71:0]  cmd_tdata;
    logic         cmd_tvalid;
    logic         cmd_tready;
    logic [127:0] tdata;
    logic [15:0]  tkeep;
    logic         tlast;
    logic         tvalid;
    logic         tready;
    logic [7:0]   sts_tdata;
    logic         sts_tvalid;
    logic         sts_tready;
    logic         err_clr;
    logic [4:0]   err_flags;
    logic         timeout_err;
    logic         frame_done_irq;

    int tests = 0;
    int fails = 0;

    rdmap_s2mm_feeder dut (
        .clk                    (clk),
        .rst                    (rst),
        .cmd_fifo_dout          (cmd_fifo_dout),
        .cmd_fifo_empty         (cmd_fifo_empty),
        .cmd_fifo_rd_en         (cmd_fifo_rd_en),
        .data_fifo_dout         (data_fifo_dout),
        .data_fifo_empty        (data_fifo_empty),
        .data_fifo_rd_en        (data_fifo_rd_en),
        .m_axis_s2mm_cmd_tdata  (cmd_tdata),
        .m_axis_s2mm_cmd_tvalid (cmd_tvalid),
        .m_axis_s2mm_cmd_tready (cmd_tready),
        .m_axis_s2mm_tdata      (tdata),
        .m_axis_s2mm_tkeep      (tkeep),
        .m_axis_s2mm_tlast      (tlast),
        .m_axis_s2mm_tvalid     (tvalid),
        .m_axis_s2mm_tready     (tready),
        .s_axis_s2mm_sts_tdata  (sts_tdata),
        .s_axis_s2mm_sts_tvalid (sts_tvalid),
        .s_axis_s2mm_sts_tready (sts_tready),
        .err_clr                (err_clr),
        .err_flags              (err_flags),
        .timeout_err            (timeout_err),
        .frame_done_irq         (frame_done_irq)
    );

    always #5 clk = ~clk;

    // FWFT FIFO models: writes from the stimulus process, reads on DUT pops
    logic [63:0]  cmd_mem  [0:255];
    logic [127:0] data_mem [0:65535];
    logic [7:0]   cmd_wr  = 8'd0;
    logic [7:0]   cmd_rd  = 8'd0;
    logic [15:0]  data_wr = 16'd0;
    logic [15:0]  data_rd = 16'd0;
    logic         flush   = 1'b0;
    int           data_seq = 0;

    assign cmd_fifo_empty  = (cmd_rd == cmd_wr);
    assign cmd_fifo_dout   = cmd_mem[cmd_rd];
    assign data_fifo_empty = (data_rd == data_wr);
    assign data_fifo_dout  = data_mem[data_rd];

    always @(posedge clk) begin
        if (flush) begin
            cmd_rd  <= cmd_wr;
            data_rd <= data_wr;
        end else begin
            if (cmd_fifo_rd_en)  cmd_rd  <= cmd_rd + 8'd1;
            if (data_fifo_rd_en) data_rd <= data_rd + 16'd1;
        end
    end

    // Handshake monitor
    logic [71:0]  got_cmd  [$];
    logic [127:0] got_data [$];
    bit           got_last [$];
    int           drop_cnt = 0;
    logic         prev_v   = 1'b0;
    logic         prev_hs  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            prev_v  <= 1'b0;
            prev_hs <= 1'b0;
        end else begin
            if (cmd_tvalid && cmd_tready) got_cmd.push_back(cmd_tdata);
            if (tvalid && tready) begin
                got_data.push_back(tdata);
                got_last.push_back(tlast);
            end
            if (prev_v && !prev_hs && !tvalid) drop_cnt = drop_cnt + 1;
            prev_v  <= tvalid;
            prev_hs <= tvalid && tready;
        end
    end

    function automatic logic [127:0] word(input int s);
        logic [31:0] v;
        v = 32'(s);
        return {v ^ 32'hA5A5_0000, v, ~v, v * 32'd3};
    endfunction

    task automatic push_cmd(input logic [63:0] c);
        cmd_mem[cmd_wr] = c;
        cmd_wr = cmd_wr + 8'd1;
    endtask

    task automatic push_data(input int n);
        for (int i = 0; i < n; i++) begin
            data_mem[data_wr] = word(data_seq);
            data_wr  = data_wr + 16'd1;
            data_seq = data_seq + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush = 1'b1;
        cmd_tready = 1'b1; tready = 1'b1; sts_tvalid = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_sts(input logic [7:0] v);
        sts_tdata  = v;
        sts_tvalid = 1'b1;
        @(negedge clk);
        sts_tvalid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (got_data.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (got_data.size() >= n);
    endtask

    task automatic wait_cmds(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (got_cmd.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (got_cmd.size() >= n);
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_tready = 1'b1; tready = 1'b1;
        sts_tvalid = 1'b0; sts_tdata = 8'h00; err_clr = 1'b0;
        flush = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b0;
        push_cmd(64'hDEAD_BEEF_0000_0001);
        @(negedge clk);
        tests++; if ({cmd_tvalid, tvalid, cmd_fifo_rd_en, data_fifo_rd_en, tlast} !== 5'b0) begin
            fails++; $display("FAIL reset_handshake: got %b required 00000", {cmd_tvalid, tvalid, cmd_fifo_rd_en, data_fifo_rd_en, tlast}); end
        tests++; if (err_flags !== 5'b0) begin fails++; $display("FAIL reset_err_flags: got %b required 00000", err_flags); end
        tests++; if ({timeout_err, frame_done_irq} !== 2'b00) begin fails++; $display("FAIL reset_timeout_irq: got %b required 00", {timeout_err, frame_done_irq}); end
        tests++; if (tkeep !== 16'hFFFF || sts_tready !== 1'b1) begin fails++; $display("FAIL reset_consts: tkeep %h sts_tready %b required FFFF 1", tkeep, sts_tready); end
        tests++; if (cmd_tdata[71:64] !== 8'h00) begin fails++; $display("FAIL reset_tag: got %h required 00", cmd_tdata[71:64]); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        int cb, db, s0, derr, lerr;
        bit ok;
        cb = got_cmd.size(); db = got_data.size(); s0 = data_seq; derr = 0; lerr = 0;
        push_cmd(64'h0123_4567_89AB_CDEF);
        push_data(256);
        wait_beats(db + 256, 700, ok);
        tests++; if (!ok) begin fails++; $display("FAIL single_done: got %0d beats required 256", got_data.size() - db); end
        tests++; if (got_cmd.size() - cb !== 1) begin fails++; $display("FAIL single_cmd_count: got %0d required 1", got_cmd.size() - cb); end
        tests++; if (got_cmd.size() > cb && got_cmd[cb] !== {8'h00, 64'h0123_4567_89AB_CDEF}) begin
            fails++; $display("FAIL single_cmd_tdata: got %h required %h", got_cmd[cb], {8'h00, 64'h0123_4567_89AB_CDEF}); end
        for (int k = 0; k < 256 && db + k < got_data.size(); k++) begin
            if (got_data[db + k] !== word(s0 + k)) derr++;
            if (got_last[db + k] !== (k == 255)) lerr++;
        end
        tests++; if (derr !== 0) begin fails++; $display("FAIL single_data: got %0d bad beats required 0", derr); end
        tests++; if (lerr !== 0) begin fails++; $display("FAIL single_tlast: got %0d misplaced tlast required 0", lerr); end
        repeat (2) @(negedge clk);
        tests++; if ({cmd_tvalid, tvalid} !== 2'b00) begin fails++; $display("FAIL single_idle: got %b required 00", {cmd_tvalid, tvalid}); end
        send_sts(8'h80);
        @(negedge clk);
        tests++; if (err_flags !== 5'b0) begin fails++; $display("FAIL single_sts: got %b required 00000", err_flags); end
    endtask

    task automatic test_backpressure();
        int cb, db, s0, dr0, derr, lerr, k;
        cb = got_cmd.size(); db = got_data.size(); s0 = data_seq; dr0 = drop_cnt; derr = 0; lerr = 0; k = 0;
        push_cmd(64'h1111_0000_0000_00A0);
        push_cmd(64'h1111_0000_0000_00A1);
        push_data(512);
        while (got_data.size() < db + 512 && k < 4000) begin
            cmd_tready = 1'($urandom_range(0, 1));
            tready     = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        cmd_tready = 1'b1; tready = 1'b1;
        tests++; if (got_data.size() - db !== 512) begin fails++; $display("FAIL bp_beats: got %0d required 512", got_data.size() - db); end
        tests++; if (got_cmd.size() - cb !== 2) begin fails++; $display("FAIL bp_cmd_count: got %0d required 2", got_cmd.size() - cb); end
        tests++; if (got_cmd.size() >= cb + 2 && (got_cmd[cb][71:64] !== 8'h01 || got_cmd[cb + 1][71:64] !== 8'h02)) begin
            fails++; $display("FAIL bp_tags: got %h %h required 01 02", got_cmd[cb][71:64], got_cmd[cb + 1][71:64]); end
        for (int i = 0; i < 512 && db + i < got_data.size(); i++) begin
            if (got_data[db + i] !== word(s0 + i)) derr++;
            if (got_last[db + i] !== ((i % 256) == 255)) lerr++;
        end
        tests++; if (derr !== 0) begin fails++; $display("FAIL bp_data: got %0d bad beats required 0", derr); end
        tests++; if (lerr !== 0) begin fails++; $display("FAIL bp_tlast: got %0d misplaced tlast required 0", lerr); end
        tests++; if (drop_cnt - dr0 !== 0) begin fails++; $display("FAIL bp_tvalid_drop: got %0d drops required 0", drop_cnt - dr0); end
        send_sts(8'h81);
        send_sts(8'h82);
        @(negedge clk);
        tests++; if (err_flags !== 5'b0) begin fails++; $display("FAIL bp_sts: got %b required 00000", err_flags); end
    endtask

    task automatic test_outstanding();
        int cb, db, terr;
        bit ok;
        do_reset();
        cb = got_cmd.size(); db = got_data.size(); terr = 0;
        for (int i = 0; i < 9; i++) push_cmd(64'hC0DE_0000_0000_0000 | 64'(i));
        push_data(9 * 256);
        wait_beats(db + 2048, 2600, ok);
        repeat (20) @(negedge clk);
        tests++; if (got_cmd.size() - cb !== 8) begin fails++; $display("FAIL outst_cmd_count: got %0d required 8", got_cmd.size() - cb); end
        tests++; if ({cmd_tvalid, tvalid} !== 2'b00) begin fails++; $display("FAIL outst_idle: got %b required 00", {cmd_tvalid, tvalid}); end
        for (int i = 0; i < 8 && cb + i < got_cmd.size(); i++)
            if (got_cmd[cb + i] !== {4'h0, 4'(i), 64'hC0DE_0000_0000_0000 | 64'(i)}) terr++;
        tests++; if (terr !== 0) begin fails++; $display("FAIL outst_tags: got %0d bad commands required 0", terr); end
        send_sts(8'h80);
        wait_cmds(cb + 9, 20, ok);
        tests++; if (!ok) begin fails++; $display("FAIL outst_ninth_issue: got %0d commands required 9", got_cmd.size() - cb); end
        tests++; if (ok && got_cmd[cb + 8] !== {8'h08, 64'hC0DE_0000_0000_0008}) begin
            fails++; $display("FAIL outst_ninth_tag: got %h required %h", got_cmd[cb + 8], {8'h08, 64'hC0DE_0000_0000_0008}); end
        wait_beats(db + 2304, 400, ok);
    endtask

    task automatic test_frame_irq();
        int db, werr, cnt;
        bit ok;
        do_reset();
        db = got_data.size(); werr = 0; cnt = 0;
        for (int i = 0; i < 128; i++) push_cmd(64'hF000_0000_0000_0000 | 64'(i));
        push_data(128 * 256);
        for (int b = 0; b < 128; b++) begin
            wait_beats(db + (b + 1) * 256, 1200, ok);
            if (!ok) werr++;
            if (b == 127) begin
                tests++; if (frame_done_irq !== 1'b0) begin fails++; $display("FAIL irq_early: got %b required 0", frame_done_irq); end
            end
            send_sts({4'h8, 4'(b)});
        end
        tests++; if (werr !== 0) begin fails++; $display("FAIL irq_bursts: got %0d stalled bursts required 0", werr); end
        tests++; if (frame_done_irq !== 1'b1) begin fails++; $display("FAIL irq_rise: got %b required 1", frame_done_irq); end
        for (int k = 0; k < 30; k++) begin
            if (frame_done_irq) cnt++;
            @(negedge clk);
        end
        tests++; if (cnt !== 24) begin fails++; $display("FAIL irq_width: got %0d cycles required 24", cnt); end
        tests++; if (err_flags !== 5'b0) begin fails++; $display("FAIL irq_err_flags: got %b required 00000", err_flags); end
    endtask

    task automatic test_errors();
        int db;
        bit ok;
        do_reset();
        db = got_data.size();
        push_cmd(64'hE000_0000_0000_0001);
        push_data(256);
        wait_beats(db + 256, 700, ok);
        send_sts(8'h41);
        tests++; if (err_flags !== 5'b01100) begin fails++; $display("FAIL err_slverr_tag: got %b required 01100", err_flags); end
        send_sts(8'h80);
        tests++; if (err_flags !== 5'b11100) begin fails++; $display("FAIL err_unexpected: got %b required 11100", err_flags); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests++; if (err_flags !== 5'b00000) begin fails++; $display("FAIL err_clear: got %b required 00000", err_flags); end
        err_clr = 1'b1;
        send_sts(8'h80);
        err_clr = 1'b0;
        tests++; if (err_flags !== 5'b10000) begin fails++; $display("FAIL err_clr_vs_event: got %b required 10000", err_flags); end
    endtask

    task automatic test_reset_mid_burst();
        int db;
        bit ok;
        do_reset();
        db = got_data.size();
        push_cmd(64'hAB00_0000_0000_0001);
        push_data(256);
        wait_beats(db + 100, 400, ok);
        rst = 1'b1;
        #1;
        tests++; if ({tvalid, data_fifo_rd_en, cmd_tvalid} !== 3'b000) begin
            fails++; $display("FAIL midrst_drop: got %b required 000", {tvalid, data_fifo_rd_en, cmd_tvalid}); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tests++; if (tvalid !== 1'b0 || data_fifo_empty !== 1'b0) begin
            fails++; $display("FAIL midrst_idle: tvalid %b fifo_empty %b required 0 0", tvalid, data_fifo_empty); end
    endtask

    task automatic test_timeout();
        int cb;
        bit ok;
        do_reset();
        cb = got_cmd.size();
        push_cmd(64'h7000_0000_0000_0001);
        wait_cmds(cb + 1, 20, ok);
        tests++; if (!ok) begin fails++; $display("FAIL to_cmd: got %0d commands required 1", got_cmd.size() - cb); end
`ifdef RDMAP_S2MM_TIMEOUT_EN
        repeat (4080) @(negedge clk);
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_early: got %b required 0", timeout_err); end
        repeat (30) @(negedge clk);
        tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_set: got %b required 1", timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_clear: got %b required 0", timeout_err); end
`else
        repeat (200) @(negedge clk);
        tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_disabled: got %b required 0", timeout_err); end
`endif
        tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL to_stall_tvalid: got %b required 0", tvalid); end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_backpressure();
        test_outstanding();
        test_frame_irq();
        test_errors();
        test_reset_mid_burst();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rdmap_s2mm_feeder.md
Name: rdmap_s2mm_feeder

Overview:
- Drains the RD-map IQ DDR-write FIFOs (64-bit command FIFO, 128-bit data FIFO) and drives an AXI DataMover S2MM channel: command stream, data stream, status stream.
- Sits directly downstream of the RD-map IQ URAM cache stage; both FIFOs are first-word-fall-through.
- Tracks outstanding commands, checks returned status and tags, and raises a stretched frame-done interrupt after a full RD map has been committed to DDR.

Parameters:
- BURST_BEATS, 256, 128-bit data beats per command; tlast is asserted on the last beat.
- MAX_OUTSTANDING, 8, maximum number of commands issued without a returned status.
- BURSTS_PER_FRAME, 128, number of good statuses per RD-map frame.
- IRQ_WIDTH, 24, frame_done_irq pulse length in clk cycles.
- TIMEOUT_CYCLES, 4096, data-stall watchdog limit (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- cmd_fifo_dout  in  64  head of command FIFO (FWFT), passed through unmodified
- cmd_fifo_empty  in  1  command FIFO empty
- cmd_fifo_rd_en  out  1  command FIFO pop
- data_fifo_dout  in  128  head of data FIFO (FWFT)
- data_fifo_empty  in  1  data FIFO empty
- data_fifo_rd_en  out  1  data FIFO pop
- m_axis_s2mm_cmd_tdata  out  72  {4'h0, tag[3:0], cmd_fifo_dout}
- m_axis_s2mm_cmd_tvalid  out  1  command valid
- m_axis_s2mm_cmd_tready  in  1  command ready
- m_axis_s2mm_tdata  out  128  data_fifo_dout
- m_axis_s2mm_tkeep  out  16  constant 16'hFFFF
- m_axis_s2mm_tlast  out  1  last beat of burst
- m_axis_s2mm_tvalid  out  1  data valid
- m_axis_s2mm_tready  in  1  data ready
- s_axis_s2mm_sts_tdata  in  8  [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG
- s_axis_s2mm_sts_tvalid  in  1  status valid
- s_axis_s2mm_sts_tready  out  1  tied 1
- err_clr  in  1  synchronous clear of sticky error flags
- err_flags  out  5  sticky: [0] INTERR, [1] DECERR, [2] SLVERR, [3] tag mismatch, [4] unexpected status
- timeout_err  out  1  sticky watchdog flag
- frame_done_irq  out  1  frame-complete interrupt pulse

Interface (already decided): one clock, clk. Reset is rst, asynchronous, active-high. Every flop clears immediately on rst assertion.

Behaviour:
- Reset state:
  - All valids, rd_ens, tlast, err_flags, timeout_err and frame_done_irq are 0.
  - State is IDLE; tag, beat_cnt, outstanding, burst_cnt and irq_cnt are 0.
  - rst asserted mid-burst drops tvalid in the same cycle. FIFO contents are not flushed.
- FSM IDLE:
  - Move to CMD when !cmd_fifo_empty and outstanding < MAX_OUTSTANDING.
- FSM CMD:
  - cmd_tvalid = 1 (combinational from state). cmd_fifo_rd_en = cmd_tvalid & cmd_tready.
  - On the handshake: tag increments (4-bit, 15 wraps to 0), outstanding increments, move to DATA.
- FSM DATA:
  - tvalid = !data_fifo_empty (combinational); tdata = data_fifo_dout.
  - data_fifo_rd_en = tvalid & tready.
  - beat_cnt increments per handshake. tlast = (beat_cnt == BURST_BEATS-1).
  - On the tlast handshake: beat_cnt clears to 0 and the FSM returns to IDLE.
  - tvalid never drops without a handshake, because the FIFO cannot become empty without a pop.
- Latency: CMD is entered 1 cycle after the IDLE conditions are met. Zero-cycle combinational passthrough from FIFO head to AXIS.
- Status path:
  - Each status beat decrements outstanding; the expected tag counter exp_tag increments.
  - A command handshake and a status beat in the same cycle leave outstanding unchanged.
  - OKAY=0: OR bits [6:4] into err_flags[2:0].
  - TAG != exp_tag: set err_flags[3].
  - Status arriving with outstanding == 0: set err_flags[4]; outstanding stays 0 (no underflow); exp_tag unchanged.
- Frame counting:
  - Each status with OKAY=1 and all error bits 0 increments burst_cnt.
  - When burst_cnt reaches BURSTS_PER_FRAME: clear it to 0 and drive frame_done_irq high for exactly IRQ_WIDTH cycles.
  - A new frame completion during an active pulse restarts the IRQ_WIDTH count.
- err_clr clears err_flags and timeout_err the next cycle. An error event in the same cycle wins and stays set.

Optional Feature:
- RDMAP_S2MM_TIMEOUT_EN defined:
  - A stall counter runs in DATA while tvalid & !tready, or while data_fifo_empty; it clears on every handshake and outside DATA.
  - When it reaches TIMEOUT_CYCLES, timeout_err is set (sticky). The FSM does not abort.
- Undefined: no counter; timeout_err is constant 0.

Test Plan:
- Single burst: 1 cmd + 256 data words preloaded, all readies high → 1 cmd handshake with tdata[67:64]=0, then 256 beats with tlast on beat 255; FSM back in IDLE; OKAY status 0x80 → outstanding returns to 0, err_flags=0.
- Backpressure: random cmd/data tready at 50 % → every beat delivered exactly once and in order, tvalid never drops without a handshake, 256 beats per tlast.
- Outstanding limit: 9 cmds queued, no status returned → exactly 8 commands issued, FSM waits in IDLE; one status with tag 0 → 9th command issues with tag 8.
- Frame irq: 128 bursts with OKAY statuses → frame_done_irq high for exactly 24 cycles after the 128th status; burst_cnt returns to 0.
- Errors: status 0x41 with exp_tag 0 → err_flags=5'b01100; status with outstanding 0 → err_flags[4]=1; err_clr → all 0.
- Reset mid-burst at beat 100 → tvalid low immediately, state IDLE; with RDMAP_S2MM_TIMEOUT_EN defined, data FIFO empty for 4096 cycles in DATA → timeout_err=1.
